// File: rtl/button_pkg.sv
// button_pkg: shared arbiter state encoding and synchronizer depth
package button_pkg;
  localparam int SYNC_STAGES = 2;
  typedef enum logic {IDLE, PRESENT} state_t;
endpackage

// File: rtl/btn_press_pulse.sv
// btn_press_pulse: two-flop synchronizer plus rising-edge press detector, armed only after a post-reset low
module btn_press_pulse
  import button_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] vld;
  logic prev;
  logic arm;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      vld  <= '0;
      prev <= 1'b0;
      arm  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      vld  <= {vld[SYNC_STAGES-2:0], 1'b1};
      prev <= sync[SYNC_STAGES-1];
      arm  <= arm | (vld[SYNC_STAGES-1] & ~sync[SYNC_STAGES-1]);
    end
  end
  assign pulse = sync[SYNC_STAGES-1] & ~prev & arm;
endmodule

// File: rtl/button_cmd_arbiter.sv
// button_cmd_arbiter: round-robin arbiter turning button presses into a valid/ready command stream
module button_cmd_arbiter
  import button_pkg::*;
#(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic               cmd_valid,
  output logic [ID_W-1:0]    cmd_id,
  input  logic               cmd_ready,
  output logic [NUM_BTN-1:0] drop
);
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] clr;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    idx;
  logic               grant;
  state_t             state;
  state_t             state_nxt;
  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_press_pulse u_pp (
        .clk   (clk),
        .rst   (rst),
        .d     (btn[i]),
        .pulse (press[i])
      );
    end
  endgenerate
  always_comb begin
    win = '0;
    idx = '0;
    for (int o = NUM_BTN; o >= 1; o--) begin
      idx = ID_W'((int'(last_grant) + o) % NUM_BTN);
      win = pending[idx] ? idx : win;
    end
  end
  assign grant     = (state == IDLE) && |pending;
  assign clr       = grant ? (NUM_BTN'(1) << win) : '0;
  assign drop      = press & pending & ~clr;
  assign cmd_valid = (state == PRESENT);
  always_comb begin
    state_nxt = state;
    state_nxt = grant ? PRESENT : (state == PRESENT && cmd_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= ID_W'(NUM_BTN - 1);
      cmd_id     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~clr) | press;
      if (grant) begin
        cmd_id     <= win;
        last_grant <= win;
      end
    end
  end
endmodule

// File: tb/tb_button_cmd_arbiter.sv
// tb_button_cmd_arbiter: directed scenarios plus randomized run against a behavioural arbiter model
module tb_button_cmd_arbiter;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic         cmd_ready = 1'b0;
  logic         cmd_valid;
  logic [1:0]   cmd_id;
  logic [N-1:0] drop;
  int checks = 0;
  int errors = 0;
  logic [N-1:0] m_pend, s1, s2, s3;
  int  m_last, m_id, m_cnt;
  bit  m_valid;
  always #5 clk = ~clk;
  button_cmd_arbiter #(.NUM_BTN(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_ready (cmd_ready),
    .drop      (drop)
  );
  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int o = 1; o <= N; o++) if (p[(last + o) % N]) return (last + o) % N;
    return 0;
  endfunction
  function automatic logic [N-1:0] press_now();
    return (m_cnt >= 3) ? (s2 & ~s3) : '0;
  endfunction
  function automatic logic [N-1:0] clr_now();
    logic [N-1:0] v;
    v = '0;
    if (!m_valid && m_pend != 0) v[rr_pick(m_pend, m_last)] = 1'b1;
    return v;
  endfunction
  function automatic logic [N-1:0] exp_drop();
    return press_now() & m_pend & ~clr_now();
  endfunction
  task automatic model_reset();
    m_pend = '0; m_last = N - 1; m_valid = 0; m_id = 0; m_cnt = 0;
    s1 = '0; s2 = '0; s3 = '0;
  endtask
  task automatic tick(input logic [N-1:0] b, input logic r);
    logic [N-1:0] p, c;
    btn = b;
    cmd_ready = r;
    @(posedge clk);
    p = press_now();
    c = clr_now();
    if (c != 0) begin
      m_id = rr_pick(m_pend, m_last);
      m_last = m_id;
      m_valid = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    m_pend = (m_pend & ~c) | p;
    s3 = s2; s2 = s1; s1 = b;
    m_cnt++;
    @(negedge clk);
  endtask
  task automatic do_reset(input logic [N-1:0] b);
    rst = 1'b1;
    btn = b;
    cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) tick(b, 1'b1);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    btn = '1;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
    checks++;
    if (cmd_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", cmd_id); end
    checks++;
    if (drop !== 4'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0000", drop); end
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      tick('1, 1'b1);
      checks++;
      if (cmd_valid !== 1'b0 || drop !== 4'b0) begin
        errors++;
        $display("FAIL held_through_reset cyc%0d: valid=%b drop=%b expected valid=0 drop=0000", c, cmd_valid, drop);
      end
    end
  endtask
  task automatic test_single();
    logic ev;
    do_reset('0);
    for (int c = 1; c <= 6; c++) begin
      tick(4'b0001, 1'b1);
      ev = (c == 4);
      checks++;
      if (cmd_valid !== ev || (ev && cmd_id !== 2'd0) || drop !== 4'b0) begin
        errors++;
        $display("FAIL single cyc%0d: valid=%b id=%0d drop=%b expected valid=%b id=0 drop=0000", c, cmd_valid, cmd_id, drop, ev);
      end
    end
  endtask
  task automatic test_simultaneous();
    int q[$];
    logic pv;
    pv = 1'b0;
    do_reset('0);
    for (int c = 0; c < 14; c++) begin
      tick(4'b1111, 1'b1);
      if (cmd_valid) q.push_back(int'(cmd_id));
      checks++;
      if ((pv && cmd_valid) || drop !== 4'b0) begin
        errors++;
        $display("FAIL simul_gap cyc%0d: prev_valid=%b valid=%b drop=%b expected no back-to-back, drop=0000", c, pv, cmd_valid, drop);
      end
      pv = cmd_valid;
    end
    checks++;
    if (q.size() != 4 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3) begin
      errors++;
      $display("FAIL simul_order: got %p expected '{0,1,2,3}", q);
    end
  endtask
  task automatic test_backpressure();
    do_reset('0);
    repeat (4) tick(4'b0100, 1'b0);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_id !== 2'd2) begin
        errors++;
        $display("FAIL backpressure cyc%0d: valid=%b id=%0d expected valid=1 id=2", c, cmd_valid, cmd_id);
      end
      tick(4'b0100, 1'b0);
    end
    tick(4'b0100, 1'b1);
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: valid=%b expected 0", cmd_valid); end
  endtask
  task automatic test_overflow();
    int nd;
    logic [N-1:0] seq [13];
    seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010,
            4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
    nd = 0;
    do_reset('0);
    for (int c = 0; c < 13; c++) begin
      tick(seq[c], 1'b0);
      if (drop[1]) nd++;
      checks++;
      if ((drop & 4'b1101) !== 4'b0) begin errors++; $display("FAIL ovf_other_drop cyc%0d: drop=%b expected bits 0,2,3 low", c, drop); end
    end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL ovf_drop_count: got %0d expected 1", nd); end
    checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) begin errors++; $display("FAIL ovf_hold: valid=%b id=%0d expected valid=1 id=1", cmd_valid, cmd_id); end
    tick(4'b0010, 1'b1);
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_accept: valid=%b expected 0", cmd_valid); end
    tick(4'b0010, 1'b1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) begin errors++; $display("FAIL ovf_second: valid=%b id=%0d expected valid=1 id=1", cmd_valid, cmd_id); end
  endtask
  task automatic test_fairness();
    int q[$];
    do_reset('0);
    repeat (5) tick(4'b0010, 1'b1);
    repeat (2) tick(4'b0000, 1'b1);
    for (int c = 0; c < 12; c++) begin
      tick(4'b1011, 1'b1);
      if (cmd_valid) q.push_back(int'(cmd_id));
    end
    checks++;
    if (q.size() != 3 || q[0] != 3 || q[1] != 0 || q[2] != 1) begin
      errors++;
      $display("FAIL fairness: got %p expected '{3,0,1}", q);
    end
  endtask
  task automatic test_reset_mid();
    int q[$];
    do_reset('0);
    repeat (4) tick(4'b0001, 1'b0);
    checks++;
    if (cmd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: valid=%b expected 1", cmd_valid); end
    btn = 4'b1111;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_async: valid=%b expected 0 right after rst", cmd_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      tick(4'b1111, 1'b1);
      checks++;
      if (cmd_valid !== 1'b0 || drop !== 4'b0) begin
        errors++;
        $display("FAIL mid_held cyc%0d: valid=%b drop=%b expected valid=0 drop=0000", c, cmd_valid, drop);
      end
    end
    repeat (2) tick(4'b0000, 1'b1);
    for (int c = 0; c < 14; c++) begin
      tick(4'b1111, 1'b1);
      if (cmd_valid) q.push_back(int'(cmd_id));
    end
    checks++;
    if (q.size() != 4 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3) begin
      errors++;
      $display("FAIL mid_after_toggle: got %p expected '{0,1,2,3}", q);
    end
  endtask
  task automatic test_random();
    logic [N-1:0] b, ed;
    logic r;
    b = '0;
    do_reset('0);
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 3) == 0) b[k] = ~b[k];
      r = ($urandom_range(0, 2) == 0);
      tick(b, r);
      ed = exp_drop();
      checks++;
      if (cmd_valid !== m_valid || (m_valid && cmd_id !== 2'(m_id)) || drop !== ed) begin
        errors++;
        $display("FAIL random cyc%0d: valid=%b id=%0d drop=%b expected valid=%b id=%0d drop=%b",
                 c, cmd_valid, cmd_id, drop, m_valid, m_id, ed);
      end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
